// File: rtl/sync_updown_counter.sv
// sync_updown_counter: fully synchronous up/down counter with parallel load,
// count enable, programmable modulus (0..MAX_VAL), wrap or saturate at the
// bounds, a look-ahead terminal-count flag, a one-cycle event pulse and a
// sticky overflow flag.
module sync_updown_counter #(
  parameter int unsigned      WIDTH    = 4,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             evt,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             at_top;
  logic             at_bot;
  logic [WIDTH-1:0] q_next;

  assign at_top = (q == MAX_VAL);
  assign at_bot = (q == '0);
  assign qbar   = ~q;

  // An event happens exactly when counting is enabled, not overridden by load,
  // and the count sits on the bound it is moving towards.
  assign tc = en & ~load & (up ? at_top : at_bot);

  // Next count: clamped load, otherwise step within 0..MAX_VAL with wrap or hold.
  always_comb begin
    q_next = q;
    if (load) begin
      q_next = (din > MAX_VAL) ? MAX_VAL : din;
    end else if (en) begin
      if (up) begin
        if (at_top) q_next = SATURATE ? q : '0;
        else        q_next = q + ONE;
      end else begin
        if (at_bot) q_next = SATURATE ? q : MAX_VAL;
        else        q_next = q - ONE;
      end
    end
  end

  // Register count and flags; an event sets ovf and wins over clr_ovf.
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= RST_VAL;
      evt <= 1'b0;
      ovf <= 1'b0;
    end else begin
      q   <= q_next;
      evt <= tc;
      ovf <= tc | (ovf & ~clr_ovf);
    end
  end

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed bench for sync_updown_counter: a wrap instance and a saturate
// instance (both WIDTH=4, MAX_VAL=9, RST_VAL=0) share the input stimulus.
module tb_sync_updown_counter;

  typedef struct {
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic       clr;
    logic [3:0] din;
    logic       tc;    // expected before the edge
    logic [3:0] q;     // expected after the edge
    logic       evt;
    logic       ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, en, up, load, clr_ovf;
  logic [3:0] din;
  logic [3:0] q_w, qbar_w, q_s, qbar_s;
  logic       tc_w, evt_w, ovf_w, tc_s, evt_s, ovf_s;

  int applied = 0;
  int miscompares = 0;

  vec_t vecs_w[$];
  vec_t vecs_s[$];

  always #5 clk = ~clk;

  sync_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0), .RST_VAL(4'd0)) dut_w (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din), .clr_ovf(clr_ovf),
    .q(q_w), .qbar(qbar_w), .tc(tc_w), .evt(evt_w), .ovf(ovf_w)
  );

  sync_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1), .RST_VAL(4'd0)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din), .clr_ovf(clr_ovf),
    .q(q_s), .qbar(qbar_s), .tc(tc_s), .evt(evt_s), .ovf(ovf_s)
  );

  function automatic vec_t mk(input logic r, e, u, l, c, input logic [3:0] d,
                              input logic t, input logic [3:0] eq, input logic ee, eo);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.load = l; v.clr = c; v.din = d;
    v.tc = t; v.q = eq; v.evt = ee; v.ovf = eo;
    return v;
  endfunction

  task automatic apply(input vec_t v, input bit sat, input int idx);
    logic [3:0] aq, aqb;
    logic       atc, aevt, aovf;
    rst = v.rst; en = v.en; up = v.up; load = v.load; clr_ovf = v.clr; din = v.din;
    @(negedge clk);
    atc = sat ? tc_s : tc_w;
    if (atc !== v.tc) begin
      miscompares++;
      $display("FAIL %s[%0d] tc: got %b, want %b", sat ? "sat" : "wrap", idx, atc, v.tc);
    end
    @(posedge clk);
    #1;
    applied++;
    aq   = sat ? q_s    : q_w;
    aqb  = sat ? qbar_s : qbar_w;
    aevt = sat ? evt_s  : evt_w;
    aovf = sat ? ovf_s  : ovf_w;
    if (aq !== v.q) begin
      miscompares++;
      $display("FAIL %s[%0d] q: got %0d, want %0d", sat ? "sat" : "wrap", idx, aq, v.q);
    end
    if (aqb !== ~v.q) begin
      miscompares++;
      $display("FAIL %s[%0d] qbar: got %b, want %b", sat ? "sat" : "wrap", idx, aqb, ~v.q);
    end
    if (aevt !== v.evt) begin
      miscompares++;
      $display("FAIL %s[%0d] evt: got %b, want %b", sat ? "sat" : "wrap", idx, aevt, v.evt);
    end
    if (aovf !== v.ovf) begin
      miscompares++;
      $display("FAIL %s[%0d] ovf: got %b, want %b", sat ? "sat" : "wrap", idx, aovf, v.ovf);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; clr_ovf = 1'b0; din = 4'd0;

    //                 rst en up ld clr din    tc  q     evt ovf
    // reset for two cycles, then count up 12 edges: 0..9,0,1,2
    vecs_w.push_back(mk(1, 0, 0, 0, 0, 4'd0,  0, 4'd0, 0, 0));
    vecs_w.push_back(mk(1, 0, 0, 0, 0, 4'd0,  0, 4'd0, 0, 0));
    for (int k = 0; k < 9; k++)
      vecs_w.push_back(mk(0, 1, 1, 0, 0, 4'd0, 0, 4'(k + 1), 0, 0));
    vecs_w.push_back(mk(0, 1, 1, 0, 0, 4'd0,  1, 4'd0, 1, 1));
    vecs_w.push_back(mk(0, 1, 1, 0, 0, 4'd0,  0, 4'd1, 0, 1));
    vecs_w.push_back(mk(0, 1, 1, 0, 0, 4'd0,  0, 4'd2, 0, 1));
    // load 2 (load masks tc), then count down through the wrap: 1,0,9,8
    vecs_w.push_back(mk(0, 1, 0, 1, 0, 4'd2,  0, 4'd2, 0, 1));
    vecs_w.push_back(mk(0, 1, 0, 0, 0, 4'd0,  0, 4'd1, 0, 1));
    vecs_w.push_back(mk(0, 1, 0, 0, 0, 4'd0,  0, 4'd0, 0, 1));
    vecs_w.push_back(mk(0, 1, 0, 0, 0, 4'd0,  1, 4'd9, 1, 1));
    vecs_w.push_back(mk(0, 1, 0, 0, 0, 4'd0,  0, 4'd8, 0, 1));
    // load clamp to MAX_VAL, then load at q=9 counting up: no tc, no event
    vecs_w.push_back(mk(0, 1, 1, 1, 0, 4'hF,  0, 4'd9, 0, 1));
    vecs_w.push_back(mk(0, 1, 1, 1, 0, 4'd3,  0, 4'd3, 0, 1));
    // rst beats load and en
    vecs_w.push_back(mk(1, 1, 1, 1, 0, 4'd7,  0, 4'd0, 0, 0));
    // ovf race: clr_ovf on the wrap edge keeps ovf, next edge clears it
    vecs_w.push_back(mk(0, 0, 0, 1, 0, 4'd9,  0, 4'd9, 0, 0));
    vecs_w.push_back(mk(0, 1, 1, 0, 1, 4'd0,  1, 4'd0, 1, 1));
    vecs_w.push_back(mk(0, 0, 1, 0, 1, 4'd0,  0, 4'd0, 0, 0));
    // direction changes take effect on the very next edge
    vecs_w.push_back(mk(0, 1, 0, 0, 0, 4'd0,  1, 4'd9, 1, 1));
    vecs_w.push_back(mk(0, 1, 1, 0, 0, 4'd0,  1, 4'd0, 1, 1));
    // count to 5, hold with en low, then reset with en high
    for (int k = 0; k < 5; k++)
      vecs_w.push_back(mk(0, 1, 1, 0, 0, 4'd0, 0, 4'(k + 1), 0, 1));
    for (int k = 0; k < 3; k++)
      vecs_w.push_back(mk(0, 0, 1, 0, 0, 4'd0, 0, 4'd5, 0, 1));
    vecs_w.push_back(mk(1, 1, 1, 0, 0, 4'd0,  0, 4'd0, 0, 0));

    // saturate instance: load 8, climb to 9 and stick, step down, stick at 0
    vecs_s.push_back(mk(1, 0, 0, 0, 0, 4'd0,  0, 4'd0, 0, 0));
    vecs_s.push_back(mk(0, 1, 1, 1, 0, 4'd8,  0, 4'd8, 0, 0));
    vecs_s.push_back(mk(0, 1, 1, 0, 0, 4'd0,  0, 4'd9, 0, 0));
    vecs_s.push_back(mk(0, 1, 1, 0, 0, 4'd0,  1, 4'd9, 1, 1));
    vecs_s.push_back(mk(0, 1, 1, 0, 0, 4'd0,  1, 4'd9, 1, 1));
    vecs_s.push_back(mk(0, 1, 0, 0, 0, 4'd0,  0, 4'd8, 0, 1));
    vecs_s.push_back(mk(0, 1, 0, 1, 0, 4'd0,  0, 4'd0, 0, 1));
    vecs_s.push_back(mk(0, 1, 0, 0, 1, 4'd0,  1, 4'd0, 1, 1));
    vecs_s.push_back(mk(0, 0, 0, 0, 1, 4'd0,  0, 4'd0, 0, 0));

    foreach (vecs_w[i]) apply(vecs_w[i], 1'b0, i);
    foreach (vecs_s[i]) apply(vecs_s[i], 1'b1, i);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
